apb_master_bridge: RTL and testbench

- APB3 requester (initiator) for the peripheral subsystem; the counterpart of our APB completer-side FSMs in the UART and sensor IPs.
- Accepts one command at a time on a simple valid/ready command port, runs the APB SETUP and ACCESS phases, and honours completer wait states (pready) and errors (pslverr).
- Returns a single-cycle response pulse carrying read data and error status.
- A programmable watchdog aborts transfers whose completer never asserts pready.

---
 rtl/apb_master_bridge.sv | 159 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3 requester: one command at a time through SETUP/ACCESS, with wait-state
// handling, slave-error passthrough and a watchdog that aborts stalled transfers.
module apb_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam int CNT_W = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  // The abort fires on the edge that ends the last allowed low-pready cycle.
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;

  logic done_s, timeout_s;

  assign done_s    = (state_q == ACCESS) && pready;
  assign timeout_s = WD_EN && (state_q == ACCESS) && !pready && (wdog_q == WD_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (done_s || timeout_s) ? IDLE : ACCESS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wdog_d      = wdog_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          wdog_d   = '0;
        end else begin
          psel_d   = 1'b0;
        end
        penable_d = 1'b0;
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (done_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (timeout_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (WD_EN) begin
          wdog_d = wdog_q + CNT_W'(1);
        end else begin
          wdog_d = wdog_q;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wdog_q      <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wdog_q      <= wdog_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model checked every cycle,
// directed test-plan scenarios with literal expectations, then random traffic.
module tb_apb_master_bridge;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction model: busy flag plus number of edges since the command was accepted.
  bit            m_busy;
  int            m_edges;
  logic          e_ready, e_psel, e_penable, e_pwrite, e_rsp_valid, e_rsp_err;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rsp_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_edges = 0;
    e_ready = 1'b1; e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0;
    e_paddr = '0; e_pwdata = '0;
    e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_rsp_rdata = '0;
  endtask

  task automatic model_edge();
    e_rsp_valid = 1'b0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1; m_edges = 0;
        e_pwrite = cmd_write; e_paddr = cmd_addr; e_pwdata = cmd_wdata;
        e_psel = 1'b1; e_penable = 1'b0; e_ready = 1'b0;
      end
    end else begin
      m_edges++;
      if (m_edges == 1) begin
        e_penable = 1'b1;
      end else if (pready || (m_edges - 1 == TO)) begin
        // m_edges-1 ACCESS cycles have now ended; completion wins over the limit
        e_rsp_valid = 1'b1;
        e_rsp_err   = pready ? pslverr : 1'b1;
        e_rsp_rdata = (pready && !e_pwrite) ? prdata : '0;
        e_psel = 1'b0; e_penable = 1'b0; e_ready = 1'b1; m_busy = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("cmd_ready", cmd_ready, e_ready);
    chk("psel", psel, e_psel);
    chk("penable", penable, e_penable);
    chk("pwrite", pwrite, e_pwrite);
    chk("paddr", paddr, e_paddr);
    chk("pwdata", pwdata, e_pwdata);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("rsp_err", rsp_err, e_rsp_err);
    chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    cyc++;
    @(negedge pclk);
    compare();
  endtask

  // Issue one command from IDLE; pready rises on ACCESS edge number waits+1.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic err, input logic [DW-1:0] rd,
                         output int lat, output int en_cnt);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    pready = 1'b0; pslverr = err; prdata = rd;
    step();
    cmd_valid = 1'b0;
    lat = -1; en_cnt = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      pready = (k == 2 + waits);
      step();
      if (penable) en_cnt++;
      if (rsp_valid) lat = k;
    end
    pready = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within 20 cycles");
    end
  endtask

  task automatic async_reset_pulse();
    #2 preset = 1'b1;
    model_reset();
    #1 compare();
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    compare();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "hang");
  end

  initial begin
    int lat, en, rsp_cnt, last_rsp, gap_ok, stall;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    model_reset();
    #1 compare();
    chk("reset_psel", psel, 1'b0);
    @(negedge pclk);
    preset = 1'b0;
    compare();
    chk("reset_ready", cmd_ready, 1'b1);

    // Write, zero wait states
    run_cmd(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, 32'hFFFF_FFFF, lat, en);
    chk("wr_lat", lat, 2);
    chk("wr_en_cycles", en, 1);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_paddr", paddr, 8'h04);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF);
    step();
    chk("wr_pulse_end", rsp_valid, 1'b0);

    // Read, two wait states
    run_cmd(1'b0, 8'h10, 32'h0, 2, 1'b0, 32'h00A5_5A00, lat, en);
    chk("rd_lat", lat, 4);
    chk("rd_en_cycles", en, 3);
    chk("rd_rdata", rsp_rdata, 32'h00A5_5A00);
    chk("rd_err", rsp_err, 1'b0);
    step();

    // Slave error on a read
    run_cmd(1'b0, 8'h20, 32'h0, 0, 1'b1, 32'h0000_1234, lat, en);
    chk("se_err", rsp_err, 1'b1);
    chk("se_rdata", rsp_rdata, 32'h0000_1234);
    step();
    chk("se_pulse_end", rsp_valid, 1'b0);

    // Watchdog abort after TO low-pready ACCESS cycles
    run_cmd(1'b0, 8'h30, 32'h0, 99, 1'b0, 32'h5555_AAAA, lat, en);
    chk("to_lat", lat, 5);
    chk("to_en_cycles", en, 4);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_psel", psel, 1'b0);
    step();

    // pready on the 4th ACCESS cycle: completion beats the watchdog
    run_cmd(1'b0, 8'h31, 32'h0, 3, 1'b0, 32'hCAFE_0001, lat, en);
    chk("tolim_lat", lat, 5);
    chk("tolim_err", rsp_err, 1'b0);
    chk("tolim_rdata", rsp_rdata, 32'hCAFE_0001);
    step();

    // Back-to-back with cmd_valid held
    cmd_valid = 1'b1; cmd_write = 1'b1; pready = 1'b1; pslverr = 1'b0;
    rsp_cnt = 0; last_rsp = -100; gap_ok = 1;
    for (int i = 0; i < 9; i++) begin
      cmd_addr = AW'(8'h40 + i); cmd_wdata = DW'(i);
      step();
      if (rsp_valid) begin
        if (rsp_cnt > 0 && cyc - last_rsp != 3) gap_ok = 0;
        rsp_cnt++; last_rsp = cyc;
      end
    end
    cmd_valid = 1'b0; pready = 1'b0;
    chk("b2b_count", rsp_cnt, 3);
    chk("b2b_spacing", gap_ok, 1);
    step();

    // Reset during an ACCESS wait state
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    #2 preset = 1'b1;
    model_reset();
    #1 compare();
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    compare();
    chk("rst_ready", cmd_ready, 1'b1);
    step();
    run_cmd(1'b1, 8'h66, 32'h1357_9BDF, 0, 1'b0, 32'h0, lat, en);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_err", rsp_err, 1'b0);

    // Random traffic, including stalls long enough to trip the watchdog
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      prdata    = $urandom;
      pslverr   = ($urandom_range(0, 3) == 0);
      if (stall > 0) begin
        pready = 1'b0; stall--;
      end else if ($urandom_range(0, 15) == 0) begin
        stall = $urandom_range(2, 7); pready = 1'b0;
      end else begin
        pready = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
